// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter:
//   - arb_state_t    : arbiter transaction state (IDLE, ISSUE, WAIT, DELIVER)
//   - MEM_CMD_READ / MEM_CMD_WRITE : command encoding shared with the memory
//   - onehot_to_index: port index of a one-hot grant vector (up to MAX_PORTS)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MAX_PORTS = 8;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } arb_state_t;

    // Index of the set bit; the vector is expected to be one-hot or zero.
    function automatic logic [2:0] onehot_to_index(input logic [MAX_PORTS-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// ---------------------------------------------------------------------------
// mem_arb_picker
// Combinational winner selection among the valid requesters.
//   MEM_ARB_ROUND_ROBIN_EN defined   : first valid port at or after rr_ptr
//                                      (wrapping) wins.
//   MEM_ARB_ROUND_ROBIN_EN undefined : lowest valid index wins; rr_ptr ignored.
// Ports:
//   req_valid [NUM_PORTS-1:0] in  per-port request valid
//   rr_ptr    [PTR_W-1:0]     in  round-robin search start
//   grant     [NUM_PORTS-1:0] out one-hot winner (zero when nothing is valid)
// ---------------------------------------------------------------------------
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Requests at or above the pointer get first pick; if none, the search
    // wraps to the lowest valid port overall.
    logic [NUM_PORTS-1:0] upper_valid;

    assign upper_valid = req_valid & ({NUM_PORTS{1'b1}} << rr_ptr);

    // x & -x isolates the lowest set bit.
    assign grant = (|upper_valid) ? (upper_valid & (-upper_valid))
                                  : (req_valid & (-req_valid));
`else
    logic unused_rr_ptr;

    assign unused_rr_ptr = ^rr_ptr;

    // x & -x isolates the lowest set bit.
    assign grant = req_valid & (-req_valid);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between NUM_PORTS requesters with a single
// outstanding transaction: accept (IDLE) -> command handshake (ISSUE) ->
// await memory response (WAIT) -> return it to the owner (DELIVER).
// Arbitration policy selected by macro MEM_ARB_ROUND_ROBIN_EN (round-robin
// when defined, fixed lowest-index priority otherwise).
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_cmd [NUM_PORTS]    requester command handshake
//   req_addr  [NUM_PORTS*ADDRESS_WIDTH]        packed, port i at [i*AW +: AW]
//   req_wdata [NUM_PORTS*DATA_WIDTH]           packed write data
//   rsp_valid/rsp_ready [NUM_PORTS]            requester response handshake
//   rsp_data  [DATA_WIDTH]                     shared read data, 0 for writes
//   mem_address/mem_wdata/mem_cmd/mem_valid/mem_ready   memory command side
//   mem_res_valid/mem_rdata/mem_res_ready               memory response side
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               req_valid,
    output logic [NUM_PORTS-1:0]               req_ready,
    input  logic [NUM_PORTS-1:0]               req_cmd,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]               rsp_valid,
    input  logic [NUM_PORTS-1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic [ADDRESS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic                               mem_cmd,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    input  logic                               mem_res_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               mem_res_ready
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t               state, state_n;
    logic [PTR_W-1:0]         owner;
    logic [PTR_W-1:0]         rr_ptr;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     lat_cmd;
    logic [DATA_WIDTH-1:0]    rsp_data_q;

    logic [NUM_PORTS-1:0]     grant;
    logic [PTR_W-1:0]         grant_idx;
    logic [NUM_PORTS-1:0]     owner_onehot;
    logic                     rsp_fire;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     sel_cmd;

    mem_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant)
    );

    assign grant_idx    = PTR_W'(onehot_to_index(MAX_PORTS'(grant)));
    assign owner_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;
    assign rsp_fire     = |(rsp_ready & owner_onehot);

    // AND-OR mux of the winner's fields; grant is one-hot so at most one
    // iteration contributes.
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_cmd   = MEM_CMD_READ;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_cmd   = req_cmd[i];
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_n       = state;
        req_ready     = '0;
        mem_valid     = 1'b0;
        mem_res_ready = 1'b0;
        rsp_valid     = '0;
        case (state)
            IDLE: begin
                // Accepting here drains a stale response left by a reset.
                mem_res_ready = 1'b1;
                req_ready     = grant;
                if (|grant) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                mem_res_ready = 1'b1;
                if (mem_res_valid) begin
                    state_n = DELIVER;
                end
            end
            DELIVER: begin
                rsp_valid = owner_onehot;
                if (rsp_fire) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_cmd    <= MEM_CMD_READ;
            rsp_data_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        owner     <= grant_idx;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_cmd   <= sel_cmd;
                    end
                end
                WAIT: begin
                    // mem_rdata is only looked at on the capture edge.
                    if (mem_res_valid) begin
                        rsp_data_q <= (lat_cmd == MEM_CMD_READ) ? mem_rdata : '0;
                    end
                end
                DELIVER: begin
                    if (rsp_fire) begin
                        rr_ptr <= (owner == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                   : owner + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_address = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign mem_cmd     = lat_cmd;
    assign rsp_data    = rsp_data_q;

    // Protocol checks; ignored by synthesis.
    a_no_res_in_issue: assert property (@(posedge clk) disable iff (!reset)
        !(state == ISSUE && mem_res_valid));
    a_rsp_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(rsp_valid));
    a_req_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(req_ready));

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural single-ported memory and a
// response scoreboard. Expected grant order follows MEM_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NP          = 2;
    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int READ_DELAY  = 22;
    localparam int WRITE_DELAY = 7;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_cmd   = '0;
    logic [NP*AW-1:0] req_addr  = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP-1:0]    rsp_ready = '1;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_wdata;
    logic             mem_cmd;
    logic             mem_valid;
    logic             mem_ready;
    logic             mem_res_ready;

    // Behavioural memory
    logic             mem_busy      = 1'b0;
    logic             mem_res_valid = 1'b0;
    logic [DW-1:0]    mem_rdata     = 'x;
    int               mem_cnt       = 0;
    logic             mem_pcmd      = 1'b0;
    logic [7:0]       mem_pidx      = '0;
    logic [DW-1:0]    mem_array   [0:255];
    logic             mem_wr_flag [0:255] = '{default: 1'b0};

    exp_t             sb[$];
    exp_t             mon_e;
    logic [DW-1:0]    shadow [int];

    int tests = 0;
    int fails = 0;
    int mem_hs = 0;
    int rr0_cycles = 0;
    int rsp1_cycles = 0;
    int rsp_any_cycles = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS     (NP),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_cmd       (mem_cmd),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_res_valid (mem_res_valid),
        .mem_rdata     (mem_rdata),
        .mem_res_ready (mem_res_ready)
    );

    function automatic logic [DW-1:0] init_value(input int w);
        case (w)
            4:       return 32'hDEAD_BEEF;
            12:      return 32'hCAFE_F00D;
            16:      return 32'h0BAD_F00D;
            default: return 32'hA500_0000 | DW'(w);
        endcase
    endfunction

    assign mem_ready = !mem_busy;

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            mem_busy <= 1'b1;
            mem_pcmd <= mem_cmd;
            mem_pidx <= mem_address[9:2];
            mem_cnt  <= (mem_cmd == MEM_CMD_WRITE) ? WRITE_DELAY : READ_DELAY;
            if (mem_cmd == MEM_CMD_WRITE) begin
                mem_array[mem_address[9:2]]   <= mem_wdata;
                mem_wr_flag[mem_address[9:2]] <= 1'b1;
            end
        end else if (mem_busy && !mem_res_valid) begin
            if (mem_cnt > 1) begin
                mem_cnt <= mem_cnt - 1;
            end else begin
                mem_res_valid <= 1'b1;
                if (mem_pcmd == MEM_CMD_WRITE)
                    mem_rdata <= 32'hBAD0_BAD0;
                else
                    mem_rdata <= mem_wr_flag[mem_pidx] ? mem_array[mem_pidx]
                                                       : init_value(int'(mem_pidx));
            end
        end else if (mem_res_valid && mem_res_ready) begin
            mem_res_valid <= 1'b0;
            mem_busy      <= 1'b0;
            mem_rdata     <= 'x;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Activity monitors
    always @(posedge clk) if (mem_valid && mem_ready) mem_hs <= mem_hs + 1;

    always @(negedge clk) begin
        if (req_ready[0]) rr0_cycles <= rr0_cycles + 1;
        if (rsp_valid[1]) rsp1_cycles <= rsp1_cycles + 1;
        if (rsp_valid != '0) rsp_any_cycles <= rsp_any_cycles + 1;
    end

    // Scoreboard: pop on every response handshake
    always @(negedge clk) begin
        if ((rsp_valid & rsp_ready) != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_port", 64'(rsp_valid), 64'(NP'(1) << mon_e.port));
                check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
            end
        end
    end

    function automatic void push_expected(input int p, input logic cmd,
                                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        int   w;
        w = int'(addr[9:2]);
        e.port = p;
        if (cmd == MEM_CMD_WRITE) begin
            shadow[w] = wd;
            e.data    = '0;
        end else begin
            e.data = shadow.exists(w) ? shadow[w] : init_value(w);
        end
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
        req_valid[p]            = 1'b1;
        req_cmd[p]              = cmd;
        req_addr[p*AW +: AW]    = addr;
        req_wdata[p*DW +: DW]   = wd;
    endtask

    // Raise a request, wait for its grant, check the command then presented
    // to memory in the first ISSUE cycle.
    task automatic send(input int p, input logic cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit expect_rsp);
        int cyc;
        cyc = 0;
        tick();
        set_req(p, cmd, addr, wd);
        @(negedge clk);
        while (!req_ready[p] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("accept", 64'(req_ready[p]), 64'd1);
        if (req_ready[p] && expect_rsp) push_expected(p, cmd, addr, wd);
        tick();
        req_valid[p] = 1'b0;
        @(negedge clk);
        check("issue_valid", 64'(mem_valid), 64'd1);
        check("issue_addr", 64'(mem_address), 64'(addr));
        check("issue_cmd", 64'(mem_cmd), 64'(cmd));
        check("issue_wdata", 64'(mem_wdata), 64'(wd));
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_mem, b_rr0, b_rsp1, b_rsp_any, n, cyc, g;
        int idx[NP];
        int exp_order[6];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_cmd", 64'(mem_cmd), 64'd0);
        check("rst_mem_res_ready", 64'(mem_res_ready), 64'd1);
        tick();
        reset = 1'b1;

        // Single read
        b_mem  = mem_hs;
        b_rr0  = rr0_cycles;
        b_rsp1 = rsp1_cycles;
        send(0, MEM_CMD_READ, 32'h10, 32'h0, 1'b1);
        drain("t1_drain");
        check("t1_req_ready0_pulses", 64'(rr0_cycles - b_rr0), 64'd1);
        check("t1_mem_handshakes", 64'(mem_hs - b_mem), 64'd1);
        check("t1_rsp1_quiet", 64'(rsp1_cycles - b_rsp1), 64'd0);

        // Write then read
        send(1, MEM_CMD_WRITE, 32'h20, 32'h1234_5678, 1'b1);
        drain("t2_write_drain");
        send(0, MEM_CMD_READ, 32'h20, 32'h0, 1'b1);
        drain("t2_read_drain");

        // Port 1 completes last, so a round-robin pointer restarts at port 0.
        send(1, MEM_CMD_READ, 32'h44, 32'h0, 1'b1);
        drain("t2b_drain");

        // Contention: both ports valid continuously for 6 grants
        idx[0] = 0;
        idx[1] = 0;
        tick();
        set_req(0, MEM_CMD_READ, 32'h80, 32'h0);
        set_req(1, MEM_CMD_READ, 32'hC0, 32'h0);
        n   = 0;
        cyc = 0;
        while (n < 6 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                g = req_ready[1] ? 1 : 0;
                check("t3_grant_order", 64'(g), 64'(exp_order[n]));
                push_expected(g, MEM_CMD_READ, req_addr[g*AW +: AW], 32'h0);
                tick();
                idx[g]++;
                set_req(g, MEM_CMD_READ, ((g == 0) ? 32'h80 : 32'hC0) + 32'(4 * idx[g]), 32'h0);
                n++;
            end
        end
        check("t3_six_grants", 64'(n), 64'd6);
        req_valid = '0;
        drain("t3_drain");

        // Backpressure on port 0 with port 1 waiting
        tick();
        rsp_ready[0] = 1'b0;
        send(0, MEM_CMD_READ, 32'h30, 32'h0, 1'b1);
        tick();
        set_req(1, MEM_CMD_READ, 32'h40, 32'h0);
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid[0] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_deliver", 64'(rsp_valid), 64'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_rsp_valid", 64'(rsp_valid), 64'b01);
            check("t4_hold_rsp_data", 64'(rsp_data), 64'hCAFE_F00D);
            check("t4_hold_no_mem_valid", 64'(mem_valid), 64'd0);
            check("t4_hold_no_grant", 64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready[0] = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!req_ready[1] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_port1_grant", 64'(req_ready), 64'b10);
        if (req_ready[1]) push_expected(1, MEM_CMD_READ, 32'h40, 32'h0);
        tick();
        req_valid = '0;
        drain("t4_drain");

        // Reset during WAIT
        b_rsp_any = rsp_any_cycles;
        send(0, MEM_CMD_READ, 32'h10, 32'h0, 1'b0);
        check("t5_mem_ready", 64'(mem_ready), 64'd1);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_req_ready", 64'(req_ready), 64'd0);
        check("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("t5_rst_rsp_data", 64'(rsp_data), 64'd0);
        check("t5_rst_mem_address", 64'(mem_address), 64'd0);
        check("t5_rst_mem_cmd", 64'(mem_cmd), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!(mem_res_valid && mem_res_ready) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_stale_drained", 64'(mem_res_valid && mem_res_ready), 64'd1);
        check("t5_no_rsp_on_stale", 64'(rsp_valid), 64'd0);
        tick();
        check("t5_stale_gone", 64'(mem_res_valid), 64'd0);
        repeat (3) tick();
        check("t5_no_rsp_cycles", 64'(rsp_any_cycles - b_rsp_any), 64'd0);
        send(0, MEM_CMD_READ, 32'h30, 32'h0, 1'b1);
        drain("t5_recover_drain");

        repeat (3) tick();
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported memory model between NUM_PORTS requesters, e.g. port 0 = instruction fetch and port 1 = operand load/store of the x86 decoder.
- Accepts one request at a time and drives the memory's valid/ready command handshake.
- Captures the memory response and returns it to the owning requester.
- Only one transaction is outstanding; requests are never reordered within a port.

Parameters:
- NUM_PORTS, 2: number of requesters (2..8).
- ADDRESS_WIDTH, 32: address width, identical to the memory.
- DATA_WIDTH, 32: data width, identical to the memory.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accepted; one-hot, high for 1 cycle.
- req_cmd  in  NUM_PORTS  per-port command; 0 = read, 1 = write.
- req_addr  in  NUM_PORTS*ADDRESS_WIDTH  packed addresses; port i at [i*AW +: AW].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_PORTS  per-port response valid; one-hot.
- rsp_ready  in  NUM_PORTS  per-port response ready.
- rsp_data  out  DATA_WIDTH  read data (shared); 0 for write responses.
- mem_address  out  ADDRESS_WIDTH  to memory i_address.
- mem_wdata  out  DATA_WIDTH  to memory i_data.
- mem_cmd  out  1  to memory i_cmd.
- mem_valid  out  1  to memory i_valid.
- mem_ready  in  1  from memory o_ready.
- mem_res_valid  in  1  from memory o_res_valid.
- mem_rdata  in  DATA_WIDTH  from memory o_data.
- mem_res_ready  out  1  to memory i_res_ready.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, owner = 0, rr_ptr = 0.
  - Latched addr/data/cmd and rsp_data cleared to 0.
  - All req_ready, rsp_valid and mem_valid = 0.
  - Reset mid-transaction abandons the transaction; no response is delivered.
- IDLE:
  - mem_res_ready = 1, so a stale memory response left over from a reset is drained and discarded.
  - If any req_valid is high, pick the winner (see Optional Feature), latch its addr/wdata/cmd, set owner.
  - req_ready[winner] = 1 in this same cycle (combinational from req_valid); go to ISSUE.
  - Losers keep req_valid asserted and must hold their request stable.
- ISSUE:
  - mem_valid = 1 with the latched fields; mem_res_ready = 0.
  - On an edge with mem_ready = 1, go to WAIT; mem_valid is 0 from the next cycle.
  - Latched fields stay stable while waiting for mem_ready.
- WAIT:
  - mem_valid = 0, mem_res_ready = 1.
  - On an edge with mem_res_valid = 1, capture rsp_data (mem_rdata for reads, 0 for writes) and go to DELIVER.
  - Any X on mem_rdata outside that capture edge is never propagated.
- DELIVER:
  - rsp_valid[owner] = 1 and rsp_data is held stable until rsp_ready[owner].
  - On that edge, go to IDLE and set rr_ptr = owner+1 (mod NUM_PORTS).
- Latency: accept-to-response = 3 cycles plus memory latency (read or write delay). Back-to-back requests pay 1 IDLE cycle between transactions.
- Simultaneous events:
  - rsp_ready on the same port in DELIVER while a new req_valid is raised: the new request is considered in the following IDLE cycle.
  - All ports valid every cycle: each port is granted once per NUM_PORTS transactions.
- Protocol checks (simulation only): assert if mem_res_valid is seen in ISSUE, or if the rsp_valid/req_ready vectors are not onehot0.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. Search starts at rr_ptr; the first valid port at or after rr_ptr (wrapping) wins.
- Undefined: fixed priority; the lowest valid index wins. rr_ptr is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DELIVER);
  - MEM_CMD_READ = 1'b0 and MEM_CMD_WRITE = 1'b1, shared with the memory;
  - a function returning a port index from a one-hot vector.
- One sub-module, mem_arb_picker: combinational, takes req_valid and rr_ptr and returns a one-hot grant. It contains the MEM_ARB_ROUND_ROBIN_EN selection.

Test Plan:
- Single read: port 0 reads 0x10, memory word 4 = 0xDEADBEEF, READ_DELAY 22 → req_ready[0] pulses once; mem_valid for exactly one accepted handshake; rsp_valid[0] with rsp_data 0xDEADBEEF; rsp_valid[1] stays 0.
- Write then read: port 1 writes 0x12345678 to 0x20, then port 0 reads 0x20 → write response rsp_data 0; read response rsp_data 0x12345678.
- Contention: both ports valid continuously, 6 transactions → with MEM_ARB_ROUND_ROBIN_EN the grant order is 0,1,0,1,0,1; without it the order is 0,0,0,0,0,0 and port 1 waits.
- Backpressure: port 0 holds rsp_ready low for 10 cycles in DELIVER → rsp_valid[0] and rsp_data stay stable; no new mem_valid; port 1 is granted only after the release.
- Reset during WAIT: pull reset low 5 cycles after the handshake → all outputs 0 immediately; after release, the stale mem_res_valid is drained in IDLE and no rsp_valid is produced; the next request completes normally.
